cyclic_lamp_checker: RTL and testbench
======================================

// Module: cyclic_lamp_checker
//
// PURPOSE
//  Receive-side monitor for the cyclic RGY lamp sequencer output. Samples the 3-bit
//  lamp bus every clock, locks onto the R->G->Y->R rotation and checks three things:
//  encoding legality, colour order and dwell time per colour.
//  Reports a one-cycle error pulse with a cause code and counts completed lamp cycles.
//  Sits beside the lamp sequencer in benches and system tops as a protocol checker.
//
// PARAMETERS
//  HOLD_CYCLES  1   exact number of consecutive clocks each colour must be held (>=1)
//  CNT_W        8   width of cycle_count (wraps modulo 2**CNT_W)
//
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  light        in   [0:2]  lamp bus; light[0]=R, light[1]=G, light[2]=Y
//  locked       out  1      1 = checker tracking a valid rotation
//  err          out  1      one-cycle pulse on any detected violation
//  err_code     out  2      cause of last error: 0 ILLEGAL, 1 ORDER, 2 SHORT, 3 LONG
//  err_seen     out  1      sticky: set on first err, cleared only by rst
//  cycle_count  out  CNT_W  completed Y->R transitions while locked
//
// BEHAVIOUR
//  - Clock and reset: single clock; rst is synchronous, active-high. All outputs are registered.
//  - Latency: light is sampled at a rising edge, and all outputs reflect that sample after the same edge.
//  - Reset values: locked=0, err=0, err_code=0, err_seen=0, cycle_count=0, state=HUNT, dwell=0.
//  - rst asserted mid-operation: overrides all logic; everything above is restored at that edge.
//  - Legal codes: 100 (R), 010 (G), 001 (Y). Every other value, including 000 and 111, is ILLEGAL.
//  - FSM states: HUNT, ON_R, ON_G, ON_Y. dwell counts clocks spent in the current colour
//    (range 1..HOLD_CYCLES).
//  - Next colour: next(R)=G, next(G)=Y, next(Y)=R.
//  - HUNT:
//    - legal sample s -> go to ON_s, dwell=1, locked=1.
//    - illegal sample -> err=1, code ILLEGAL, stay in HUNT.
//  - ON_C with sample s, first matching rule wins:
//    1. s illegal -> err, code ILLEGAL, go to HUNT, locked=0.
//    2. s==C and dwell<HOLD_CYCLES -> dwell++.
//    3. s==C and dwell==HOLD_CYCLES -> err, code LONG, re-acquire as ON_C with dwell=1.
//    4. s==next(C) and dwell==HOLD_CYCLES -> go to ON_s, dwell=1.
//       If C==Y, cycle_count++ (wraps to 0).
//    5. s==next(C) and dwell<HOLD_CYCLES -> err, code SHORT, re-acquire as ON_s with dwell=1.
//    6. Any other legal s (skip or reverse) -> err, code ORDER, re-acquire as ON_s with dwell=1.
//  - Re-acquire keeps locked=1 and does not increment cycle_count.
//  - err is high for exactly one cycle per violating sample; back-to-back violations
//    give back-to-back pulses.
//  - err_code updates only when err=1 and holds its value otherwise.
//  - err_seen is set in the same cycle as the first err.
//  - HOLD_CYCLES=1: every colour must change on every clock, so any repeat is LONG.
//  - dwell is sized $clog2(HOLD_CYCLES+1) bits and never exceeds HOLD_CYCLES.
//
// STRUCTURE
//  - Shared package lamp_pkg holds:
//    - colour encodings LAMP_R=3'b100, LAMP_G=3'b010, LAMP_Y=3'b001;
//    - the FSM state localparams (HUNT, ON_R, ON_G, ON_Y);
//    - the error codes ERR_ILLEGAL, ERR_ORDER, ERR_SHORT, ERR_LONG.
//  - The lamp sequencer reuses the colour encodings from lamp_pkg.
//  - One sub-module: lamp_dwell_counter.
//    - Inputs: clk, rst, restart, inc. Outputs: dwell, at_max.
//    - Parameter: HOLD_CYCLES.
//    - restart has priority over inc.
//  - The FSM, error logic and cycle counter stay in the top module.
//
// TESTING
//  1. rst=1 for 2 clk, light=100 -> locked=0, err=0, err_seen=0, cycle_count=0.
//  2. HOLD_CYCLES=1, drive R,G,Y x4 then R (13 samples)
//     -> locked=1 from the first edge, err never set, cycle_count=4.
//  3. HOLD_CYCLES=1, drive R then Y -> err=1 for one cycle, err_code=1 (ORDER),
//     locked stays 1; a following R is accepted with no error and cycle_count +1.
//  4. While locked, drive 011 -> err=1, err_code=0, locked=0.
//     Then drive 000 -> err=1 again. Then drive 010 -> locked=1, err=0.
//  5. HOLD_CYCLES=3: R,R,G -> err_code=2 (SHORT) on the G sample.
//     R,R,R,R -> err_code=3 (LONG) on the 4th R. err_seen=1 throughout after the first error.
//  6. Lock and run to cycle_count=5, then assert rst for 1 clk mid-dwell
//     -> next edge: cycle_count=0, locked=0, err_seen=0.
//     CNT_W=2: 4 cycles -> cycle_count wraps to 0.

Source files
------------

// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - shared lamp encodings, checker states, error codes and helpers
package lamp_pkg;

  // Lamp bus encodings, bit order {R, G, Y}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  // Checker FSM states
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ON_R = 2'd1,
    ON_G = 2'd2,
    ON_Y = 2'd3
  } lamp_state_t;

  // Error cause codes reported on err_code
  localparam logic [1:0] ERR_ILLEGAL = 2'd0;
  localparam logic [1:0] ERR_ORDER   = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

  // One-hot with exactly one lamp lit is the only legal pattern
  function automatic logic lamp_is_legal(input logic [2:0] c);
    return (c == LAMP_R) || (c == LAMP_G) || (c == LAMP_Y);
  endfunction

  // Rotation order R -> G -> Y -> R
  function automatic logic [2:0] lamp_next(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      LAMP_R:  n = LAMP_G;
      LAMP_G:  n = LAMP_Y;
      LAMP_Y:  n = LAMP_R;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  // Tracking state that corresponds to a legal colour
  function automatic lamp_state_t lamp_to_state(input logic [2:0] c);
    lamp_state_t s;
    case (c)
      LAMP_R:  s = ON_R;
      LAMP_G:  s = ON_G;
      LAMP_Y:  s = ON_Y;
      default: s = HUNT;
    endcase
    return s;
  endfunction

  // Colour being tracked in a given state (000 while hunting)
  function automatic logic [2:0] state_to_lamp(input lamp_state_t s);
    logic [2:0] c;
    case (s)
      ON_R:    c = LAMP_R;
      ON_G:    c = LAMP_G;
      ON_Y:    c = LAMP_Y;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// rtl/lamp_dwell_counter.sv - counts clocks spent on the current colour, saturating at HOLD_CYCLES
module lamp_dwell_counter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               restart,
  input  logic                               inc,
  output logic [$clog2(HOLD_CYCLES+1)-1:0]   dwell,
  output logic                               at_max
);

  localparam int DW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_ONE = DW'(1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYCLES);

  // restart wins over inc; increments stop at the hold limit so dwell never exceeds it
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
    end else if (restart) begin
      dwell <= DWELL_ONE;
    end else if (inc && (dwell != DWELL_MAX)) begin
      dwell <= dwell + DWELL_ONE;
    end
  end

  // Flag the colour as having been held for its full time
  always_comb begin
    at_max = (dwell == DWELL_MAX);
  end

endmodule

// File: rtl/cyclic_lamp_checker.sv
// rtl/cyclic_lamp_checker.sv - locks onto the R->G->Y rotation and flags encoding, order and dwell violations
module cyclic_lamp_checker
  import lamp_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:2]       light,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_seen,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYCLES);

  lamp_state_t      state;
  lamp_state_t      state_nx;
  logic [DW-1:0]    dwell;
  logic             at_max;
  logic             dwell_restart;
  logic             dwell_inc;
  logic             viol;
  logic [1:0]       viol_code;
  logic             cycle_done;

  logic [2:0]       sample;
  logic [2:0]       cur_colour;
  logic             sample_legal;
  logic             dwell_short;

  logic             locked_nx;
  logic             err_nx;
  logic [1:0]       err_code_nx;
  logic             err_seen_nx;
  logic [CNT_W-1:0] cycle_count_nx;

  lamp_dwell_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .restart (dwell_restart),
    .inc     (dwell_inc),
    .dwell   (dwell),
    .at_max  (at_max)
  );

  // Decoded view of the current sample against the colour being tracked
  always_comb begin
    sample       = light;
    cur_colour   = state_to_lamp(state);
    sample_legal = lamp_is_legal(sample);
    dwell_short  = (dwell < DWELL_MAX);
  end

  // State and registered outputs; reset overrides everything at the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_ILLEGAL;
      err_seen    <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nx;
      locked      <= locked_nx;
      err         <= err_nx;
      err_code    <= err_code_nx;
      err_seen    <= err_seen_nx;
      cycle_count <= cycle_count_nx;
    end
  end

  // Next state: rules are checked in priority order, first match wins
  always_comb begin
    state_nx      = state;
    dwell_restart = 1'b0;
    dwell_inc     = 1'b0;
    viol          = 1'b0;
    viol_code     = ERR_ILLEGAL;
    cycle_done    = 1'b0;
    if (state == HUNT) begin
      if (sample_legal) begin
        state_nx      = lamp_to_state(sample);
        dwell_restart = 1'b1;
      end else begin
        viol      = 1'b1;
        viol_code = ERR_ILLEGAL;
      end
    end else if (!sample_legal) begin
      state_nx  = HUNT;
      viol      = 1'b1;
      viol_code = ERR_ILLEGAL;
    end else if (sample == cur_colour) begin
      if (dwell_short) begin
        dwell_inc = 1'b1;
      end else begin
        // Held too long: re-acquire on the same colour with a fresh dwell
        viol          = 1'b1;
        viol_code     = ERR_LONG;
        dwell_restart = 1'b1;
      end
    end else if (sample == lamp_next(cur_colour)) begin
      state_nx      = lamp_to_state(sample);
      dwell_restart = 1'b1;
      if (at_max) begin
        cycle_done = (state == ON_Y);
      end else begin
        viol      = 1'b1;
        viol_code = ERR_SHORT;
      end
    end else begin
      // Skipped or reversed colour: re-acquire on whatever arrived
      state_nx      = lamp_to_state(sample);
      dwell_restart = 1'b1;
      viol          = 1'b1;
      viol_code     = ERR_ORDER;
    end
  end

  // Output values to be registered alongside the state
  always_comb begin
    locked_nx      = (state_nx != HUNT);
    err_nx         = viol;
    err_code_nx    = viol ? viol_code : err_code;
    err_seen_nx    = err_seen | viol;
    cycle_count_nx = cycle_done ? (cycle_count + CNT_W'(1)) : cycle_count;
  end

endmodule

// File: tb/tb_cyclic_lamp_checker.sv
// tb/tb_cyclic_lamp_checker.sv - directed self-checking bench for cyclic_lamp_checker
module tb_cyclic_lamp_checker;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic clk;
  int   checks;
  int   errors;

  // HOLD_CYCLES=1, CNT_W=8
  logic       rst1;
  logic [0:2] light1;
  logic       locked1, err1, err_seen1;
  logic [1:0] err_code1;
  logic [7:0] count1;

  // HOLD_CYCLES=3, CNT_W=8
  logic       rst3;
  logic [0:2] light3;
  logic       locked3, err3, err_seen3;
  logic [1:0] err_code3;
  logic [7:0] count3;

  // HOLD_CYCLES=1, CNT_W=2
  logic       rstw;
  logic [0:2] lightw;
  logic       lockedw, errw, err_seenw;
  logic [1:0] err_codew;
  logic [1:0] countw;

  cyclic_lamp_checker #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .light(light1), .locked(locked1), .err(err1),
    .err_code(err_code1), .err_seen(err_seen1), .cycle_count(count1)
  );

  cyclic_lamp_checker #(.HOLD_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst3), .light(light3), .locked(locked3), .err(err3),
    .err_code(err_code3), .err_seen(err_seen3), .cycle_count(count3)
  );

  cyclic_lamp_checker #(.HOLD_CYCLES(1), .CNT_W(2)) dutw (
    .clk(clk), .rst(rstw), .light(lightw), .locked(lockedw), .err(errw),
    .err_code(err_codew), .err_seen(err_seenw), .cycle_count(countw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive1(input logic [2:0] v);
    light1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [2:0] v);
    light3 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drivew(input logic [2:0] v);
    lightw = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst3 = 1'b1; rstw = 1'b1;
    light1 = R; light3 = R; lightw = R;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (locked1 !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked1); end
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err1); end
    checks++;
    if (err_seen1 !== 1'b0) begin errors++; $display("FAIL reset_err_seen: got %0b expected 0", err_seen1); end
    checks++;
    if (count1 !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count1); end
    checks++;
    if (err_code1 !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code1); end
    checks++;
    if (locked3 !== 1'b0) begin errors++; $display("FAIL reset_locked3: got %0b expected 0", locked3); end
    rst1 = 1'b0; rst3 = 1'b0; rstw = 1'b0;
  endtask

  task automatic test_rotation;
    logic [2:0] seq [13];
    seq = '{R, G, Y, R, G, Y, R, G, Y, R, G, Y, R};
    for (int i = 0; i < 13; i++) begin
      drive1(seq[i]);
      checks++;
      if (locked1 !== 1'b1) begin errors++; $display("FAIL rot_locked[%0d]: got %0b expected 1", i, locked1); end
      checks++;
      if (err1 !== 1'b0) begin errors++; $display("FAIL rot_err[%0d]: got %0b expected 0", i, err1); end
    end
    checks++;
    if (count1 !== 8'd4) begin errors++; $display("FAIL rot_count: got %0d expected 4", count1); end
    checks++;
    if (err_seen1 !== 1'b0) begin errors++; $display("FAIL rot_err_seen: got %0b expected 0", err_seen1); end
  endtask

  task automatic test_order;
    drive1(Y);
    checks++;
    if (err1 !== 1'b1) begin errors++; $display("FAIL order_err: got %0b expected 1", err1); end
    checks++;
    if (err_code1 !== 2'd1) begin errors++; $display("FAIL order_code: got %0d expected 1", err_code1); end
    checks++;
    if (locked1 !== 1'b1) begin errors++; $display("FAIL order_locked: got %0b expected 1", locked1); end
    checks++;
    if (count1 !== 8'd4) begin errors++; $display("FAIL order_count_hold: got %0d expected 4", count1); end
    drive1(R);
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL order_recover_err: got %0b expected 0", err1); end
    checks++;
    if (count1 !== 8'd5) begin errors++; $display("FAIL order_recover_count: got %0d expected 5", count1); end
    checks++;
    if (err_seen1 !== 1'b1) begin errors++; $display("FAIL order_err_seen: got %0b expected 1", err_seen1); end
    checks++;
    if (err_code1 !== 2'd1) begin errors++; $display("FAIL order_code_hold: got %0d expected 1", err_code1); end
  endtask

  task automatic test_illegal;
    drive1(3'b011);
    checks++;
    if (err1 !== 1'b1) begin errors++; $display("FAIL ill_011_err: got %0b expected 1", err1); end
    checks++;
    if (err_code1 !== 2'd0) begin errors++; $display("FAIL ill_011_code: got %0d expected 0", err_code1); end
    checks++;
    if (locked1 !== 1'b0) begin errors++; $display("FAIL ill_011_locked: got %0b expected 0", locked1); end
    drive1(3'b000);
    checks++;
    if (err1 !== 1'b1) begin errors++; $display("FAIL ill_000_err: got %0b expected 1", err1); end
    checks++;
    if (locked1 !== 1'b0) begin errors++; $display("FAIL ill_000_locked: got %0b expected 0", locked1); end
    drive1(G);
    checks++;
    if (locked1 !== 1'b1) begin errors++; $display("FAIL ill_relock: got %0b expected 1", locked1); end
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL ill_relock_err: got %0b expected 0", err1); end
    checks++;
    if (err_code1 !== 2'd0) begin errors++; $display("FAIL ill_code_hold: got %0d expected 0", err_code1); end
    checks++;
    if (count1 !== 8'd5) begin errors++; $display("FAIL ill_count_hold: got %0d expected 5", count1); end
  endtask

  task automatic test_dwell;
    drive3(R);
    drive3(R);
    checks++;
    if (err3 !== 1'b0) begin errors++; $display("FAIL dw_hold_err: got %0b expected 0", err3); end
    drive3(G);
    checks++;
    if (err3 !== 1'b1) begin errors++; $display("FAIL dw_short_err: got %0b expected 1", err3); end
    checks++;
    if (err_code3 !== 2'd2) begin errors++; $display("FAIL dw_short_code: got %0d expected 2", err_code3); end
    checks++;
    if (err_seen3 !== 1'b1) begin errors++; $display("FAIL dw_short_seen: got %0b expected 1", err_seen3); end
    // R after G skips Y: order violation, re-acquired on R
    drive3(R);
    checks++;
    if (err_code3 !== 2'd1) begin errors++; $display("FAIL dw_skip_code: got %0d expected 1", err_code3); end
    drive3(R);
    drive3(R);
    checks++;
    if (err3 !== 1'b0) begin errors++; $display("FAIL dw_third_err: got %0b expected 0", err3); end
    checks++;
    if (err_code3 !== 2'd1) begin errors++; $display("FAIL dw_code_hold: got %0d expected 1", err_code3); end
    drive3(R);
    checks++;
    if (err3 !== 1'b1) begin errors++; $display("FAIL dw_long_err: got %0b expected 1", err3); end
    checks++;
    if (err_code3 !== 2'd3) begin errors++; $display("FAIL dw_long_code: got %0d expected 3", err_code3); end
    checks++;
    if (locked3 !== 1'b1) begin errors++; $display("FAIL dw_long_locked: got %0b expected 1", locked3); end
    // Re-acquired on R with dwell 1: two more R then a clean full cycle
    drive3(R); drive3(R);
    drive3(G); drive3(G); drive3(G);
    checks++;
    if (err3 !== 1'b0) begin errors++; $display("FAIL dw_clean_err: got %0b expected 0", err3); end
    drive3(Y); drive3(Y); drive3(Y);
    drive3(R);
    checks++;
    if (count3 !== 8'd1) begin errors++; $display("FAIL dw_clean_count: got %0d expected 1", count3); end
    checks++;
    if (err_seen3 !== 1'b1) begin errors++; $display("FAIL dw_seen_sticky: got %0b expected 1", err_seen3); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      drive3(R); drive3(R);
      drive3(G); drive3(G); drive3(G);
      drive3(Y); drive3(Y); drive3(Y);
      drive3(R);
    end
    checks++;
    if (count3 !== 8'd5) begin errors++; $display("FAIL mid_count_pre: got %0d expected 5", count3); end
    drive3(R);
    rst3 = 1'b1;
    drive3(R);
    rst3 = 1'b0;
    checks++;
    if (count3 !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count3); end
    checks++;
    if (locked3 !== 1'b0) begin errors++; $display("FAIL mid_locked: got %0b expected 0", locked3); end
    checks++;
    if (err_seen3 !== 1'b0) begin errors++; $display("FAIL mid_err_seen: got %0b expected 0", err_seen3); end
    checks++;
    if (err3 !== 1'b0) begin errors++; $display("FAIL mid_err: got %0b expected 0", err3); end
  endtask

  task automatic test_wrap;
    rstw = 1'b1;
    drivew(R);
    rstw = 1'b0;
    drivew(R);
    for (int i = 0; i < 3; i++) begin
      drivew(G); drivew(Y); drivew(R);
    end
    checks++;
    if (countw !== 2'd3) begin errors++; $display("FAIL wrap_pre: got %0d expected 3", countw); end
    drivew(G); drivew(Y); drivew(R);
    checks++;
    if (countw !== 2'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", countw); end
    checks++;
    if (lockedw !== 1'b1) begin errors++; $display("FAIL wrap_locked: got %0b expected 1", lockedw); end
    checks++;
    if (err_seenw !== 1'b0) begin errors++; $display("FAIL wrap_err_seen: got %0b expected 0", err_seenw); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst1 = 1'b1; rst3 = 1'b1; rstw = 1'b1;
    light1 = R; light3 = R; lightw = R;
    test_reset;
    test_rotation;
    test_order;
    test_illegal;
    test_dwell;
    test_reset_mid;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
